// File: rtl/interface_vga.sv
// VGA 640x480 @ 60 Hz timing generator with a registered sync/blank/RGB output stage.
// Define INTERFACE_VGA_TEST_PATTERN_EN to replace the RGB input with eight vertical colour bars.
module interface_vga #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [23:0] RGB,
  output logic [9:0]  ColunaOut,
  output logic [9:0]  LinhaOut,
  output logic        h_sync,
  output logic        v_sync,
  output logic        blank,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic [9:0]  hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        h_sync_q, h_sync_d;
  logic        v_sync_q, v_sync_d;
  logic        blank_q, blank_d;
  logic [23:0] rgb_q, rgb_d;
  logic        active_s;
  logic [23:0] pixel_s;

`ifdef INTERFACE_VGA_TEST_PATTERN_EN
  function automatic logic [23:0] bar_colour(input logic [9:0] col);
    logic [3:0] bar;
    bar = 4'(col / 10'd80);
    case (bar)
      4'd0:    bar_colour = 24'hFFFFFF;
      4'd1:    bar_colour = 24'hFFFF00;
      4'd2:    bar_colour = 24'h00FFFF;
      4'd3:    bar_colour = 24'h00FF00;
      4'd4:    bar_colour = 24'hFF00FF;
      4'd5:    bar_colour = 24'hFF0000;
      4'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction
`endif

  // Scan position: column wraps every line, line advances only on column wrap.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = 10'd0;
      if (vcount_q == V_LAST) begin
        vcount_d = 10'd0;
      end else begin
        vcount_d = vcount_q + 10'd1;
      end
    end else begin
      hcount_d = hcount_q + 10'd1;
    end
  end

  // Decode of the current coordinate; registered next edge for one clock of latency.
  always_comb begin
    active_s = (hcount_q < H_VIS) && (vcount_q < V_VIS);
`ifdef INTERFACE_VGA_TEST_PATTERN_EN
    pixel_s  = bar_colour(hcount_q);
`else
    pixel_s  = RGB;
`endif
    blank_d  = active_s;
    h_sync_d = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
    v_sync_d = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
    if (active_s) begin
      rgb_d = pixel_s;
    end else begin
      rgb_d = 24'h000000;
    end
  end

  // Counters and output registers; reset restarts the scan at (0,0).
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hcount_q <= 10'd0;
      vcount_q <= 10'd0;
      h_sync_q <= 1'b1;
      v_sync_q <= 1'b1;
      blank_q  <= 1'b0;
      rgb_q    <= 24'h000000;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      h_sync_q <= h_sync_d;
      v_sync_q <= v_sync_d;
      blank_q  <= blank_d;
      rgb_q    <= rgb_d;
    end
  end

  assign ColunaOut = hcount_q;
  assign LinhaOut  = vcount_q;
  assign h_sync    = h_sync_q;
  assign v_sync    = v_sync_q;
  assign blank     = blank_q;
  assign R         = rgb_q[23:16];
  assign G         = rgb_q[15:8];
  assign B         = rgb_q[7:0];

endmodule

// File: tb/tb_interface_vga.sv
// Bench for interface_vga: a full-size instance for line timing and a small-parameter
// instance for whole-frame behaviour, both checked against a time-based reference model.
module tb_interface_vga;

  typedef struct packed {
    logic [9:0]  col;
    logic [9:0]  lin;
    logic        hs;
    logic        vs;
    logic        bl;
    logic [23:0] rgb;
  } out_t;

  typedef struct {
    int         edge_k;
    logic       exp_blank;
    logic       exp_hs;
    logic [9:0] exp_col;
    logic [9:0] exp_lin;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] rgb0  = 24'h000000;
  logic [23:0] rgb1  = 24'h000000;

  logic [9:0] col0, lin0, col1, lin1;
  logic       hs0, vs0, bl0, hs1, vs1, bl1;
  logic [7:0] r0, g0, b0, r1, g1, b1;

  int k      = 0;
  int checks = 0;
  int errors = 0;
  int phase  = 0;

  logic pbl0 = 1'b0, phs0 = 1'b1, pvs1 = 1'b1, pbl1 = 1'b0;
  int   bl_rise0 [2];
  int   hs_fall0 [2];
  int   bl_rise1 [8];
  int   n_blr0 = 0, n_hsf0 = 0, n_blr1 = 0;
  int   bl_fall0 = -1, hs_rise0 = -1, vs_fall1 = -1, vs_rise1 = -1, bl_cnt1 = 0;

  vec_t vec [10];

  interface_vga dut0 (
    .Clock(clk), .Reset(rst_n), .RGB(rgb0),
    .ColunaOut(col0), .LinhaOut(lin0),
    .h_sync(hs0), .v_sync(vs0), .blank(bl0),
    .R(r0), .G(g0), .B(b0)
  );

  interface_vga #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut1 (
    .Clock(clk), .Reset(rst_n), .RGB(rgb1),
    .ColunaOut(col1), .LinhaOut(lin1),
    .h_sync(hs1), .v_sync(vs1), .blank(bl1),
    .R(r1), .G(g1), .B(b1)
  );

  always #20 clk = ~clk;

  // Rising edges seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

`ifdef INTERFACE_VGA_TEST_PATTERN_EN
  function automatic logic [23:0] bar(input int px);
    case (px / 80)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction
`endif

  // Expected outputs after kk edges since release: coordinate is kk, registered outputs describe kk-1.
  function automatic out_t model(input int kk, input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input logic [23:0] rgb_in);
    out_t o;
    int   ht, vt, px, py;
    logic act;
    ht    = ha + hf + hsw + hb;
    vt    = va + vf + vsw + vb;
    o.col = 10'(kk % ht);
    o.lin = 10'((kk / ht) % vt);
    if (kk == 0) begin
      o.hs = 1'b1; o.vs = 1'b1; o.bl = 1'b0; o.rgb = 24'h000000;
    end else begin
      px   = (kk - 1) % ht;
      py   = ((kk - 1) / ht) % vt;
      act  = (px < ha) && (py < va);
      o.bl = act;
      o.hs = !((px >= ha + hf) && (px < ha + hf + hsw));
      o.vs = !((py >= va + vf) && (py < va + vf + vsw));
`ifdef INTERFACE_VGA_TEST_PATTERN_EN
      o.rgb = act ? bar(px) : 24'h000000;
`else
      o.rgb = act ? rgb_in : 24'h000000;
`endif
    end
    return o;
  endfunction

  task automatic cmp_out(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got col=%0d lin=%0d hs=%b vs=%b bl=%b rgb=%h expected col=%0d lin=%0d hs=%b vs=%b bl=%b rgb=%h",
               name, k, got.col, got.lin, got.hs, got.vs, got.bl, got.rgb,
               exp.col, exp.lin, exp.hs, exp.vs, exp.bl, exp.rgb);
    end
  endtask

  task automatic cmp_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_both(input string tag);
    out_t got;
    got = {col0, lin0, hs0, vs0, bl0, r0, g0, b0};
    cmp_out({tag, "_full"}, got, model(k, 640, 16, 96, 48, 480, 10, 2, 33, rgb0));
    got = {col1, lin1, hs1, vs1, bl1, r1, g1, b1};
    cmp_out({tag, "_small"}, got, model(k, 8, 2, 3, 2, 6, 2, 2, 3, rgb1));
  endtask

  task automatic measure();
    if (phase == 0 && k > 0) begin
      if (bl0 && !pbl0 && n_blr0 < 2) begin bl_rise0[n_blr0] = k; n_blr0++; end
      if (!bl0 && pbl0 && bl_fall0 < 0) bl_fall0 = k;
      if (!hs0 && phs0 && n_hsf0 < 2) begin hs_fall0[n_hsf0] = k; n_hsf0++; end
      if (hs0 && !phs0 && hs_rise0 < 0) hs_rise0 = k;
      if (!vs1 && pvs1 && vs_fall1 < 0) vs_fall1 = k;
      if (vs1 && !pvs1 && vs_rise1 < 0) vs_rise1 = k;
      if (bl1 && !pbl1 && n_blr1 < 8) begin bl_rise1[n_blr1] = k; n_blr1++; end
      if (k <= 195 && bl1) bl_cnt1++;
    end
    pbl0 = bl0; phs0 = hs0; pvs1 = vs1; pbl1 = bl1;
  endtask

  // One pixel clock: check both DUTs mid-cycle, then present RGB for the coordinate now on the bus.
  task automatic step();
    @(negedge clk);
    check_both("scan");
    measure();
    rgb0 = {8'(k % 800), 8'((k / 800) % 525), 8'hA5};
    rgb1 = 24'($urandom);
  endtask

  initial begin
    int guard;
    vec[0] = '{1,   1'b1, 1'b1, 10'd1,   10'd0};
    vec[1] = '{640, 1'b1, 1'b1, 10'd640, 10'd0};
    vec[2] = '{641, 1'b0, 1'b1, 10'd641, 10'd0};
    vec[3] = '{656, 1'b0, 1'b1, 10'd656, 10'd0};
    vec[4] = '{657, 1'b0, 1'b0, 10'd657, 10'd0};
    vec[5] = '{752, 1'b0, 1'b0, 10'd752, 10'd0};
    vec[6] = '{753, 1'b0, 1'b1, 10'd753, 10'd0};
    vec[7] = '{799, 1'b0, 1'b1, 10'd799, 10'd0};
    vec[8] = '{800, 1'b0, 1'b1, 10'd0,   10'd1};
    vec[9] = '{801, 1'b1, 1'b1, 10'd1,   10'd1};
    for (int i = 0; i < 2; i++) begin bl_rise0[i] = -1; hs_fall0[i] = -1; end
    for (int i = 0; i < 8; i++) bl_rise1[i] = -1;

    step();
    step();
    #25 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      guard = 0;
      while (k < vec[i].edge_k && guard < 2000) begin step(); guard++; end
      checks++;
      if (k != vec[i].edge_k || bl0 !== vec[i].exp_blank || hs0 !== vec[i].exp_hs ||
          col0 !== vec[i].exp_col || lin0 !== vec[i].exp_lin) begin
        errors++;
        $display("FAIL vec%0d k=%0d got bl=%b hs=%b col=%0d lin=%0d expected k=%0d bl=%b hs=%b col=%0d lin=%0d",
                 i, k, bl0, hs0, col0, lin0, vec[i].edge_k, vec[i].exp_blank, vec[i].exp_hs,
                 vec[i].exp_col, vec[i].exp_lin);
      end
    end

    guard = 0;
    while (k < 1900 && guard < 3000) begin step(); guard++; end
    cmp_int("reach_line2_col300", int'(col0) * 1000 + int'(lin0), 300 * 1000 + 2);

    phase = 1;
    #5 rst_n = 1'b0;
    #1 check_both("async_reset");
    repeat (3) step();
    #5 rst_n = 1'b1;
    step();
    cmp_int("restart_blank", int'(bl0), 1);
    cmp_int("restart_col", int'(col0), 1);
    repeat (900) step();

    cmp_int("first_blank_rise", bl_rise0[0], 1);
    cmp_int("blank_high_width", bl_fall0 - bl_rise0[0], 640);
    cmp_int("hsync_after_blank_fall", hs_fall0[0] - bl_fall0, 16);
    cmp_int("hsync_after_blank_rise", hs_fall0[0] - bl_rise0[0], 656);
    cmp_int("hsync_low_width", hs_rise0 - hs_fall0[0], 96);
    cmp_int("hsync_period", hs_fall0[1] - hs_fall0[0], 800);
    cmp_int("line_period", bl_rise0[1] - bl_rise0[0], 800);
    cmp_int("small_vsync_start", vs_fall1, 1 + 8 * 15);
    cmp_int("small_vsync_width", vs_rise1 - vs_fall1, 2 * 15);
    cmp_int("small_frame_period", bl_rise1[6] - bl_rise1[0], 195);
    cmp_int("small_blank_clocks", bl_cnt1, 6 * 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
